rx_mac: RTL
===========

RX_MAC -- requirements
Module: rx_mac

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: byte width of the RGMII and AXI-Stream data paths; only 8 is supported.
REQ-002 SHALL have parameter MIN_FRAME, default 64: minimum length of a legal frame in bytes after the SFD, FCS included.
REQ-003 SHALL have parameter MAX_FRAME, default 1518: maximum length of a legal frame in bytes after the SFD, FCS included.
REQ-004 SHALL have port clk, input, 1 bit: the single clock for the block.
REQ-005 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port rgmii_mac_rx_data, input, 8 bits: byte from the RGMII layer.
REQ-007 SHALL have port rgmii_mac_rx_dv, input, 1 bit: RGMII data valid; high for the whole frame, preamble included.
REQ-008 SHALL have port rgmii_mac_rx_er, input, 1 bit: PHY receive error.
REQ-009 SHALL have port rgmii_mac_rx_rdy, input, 1 bit: byte strobe; high every cycle at 1 Gb/s, every other cycle in MII mode.
REQ-010 SHALL have port m_rx_axis_tdata, output, 8 bits: payload byte to the RX FIFO.
REQ-011 SHALL have port m_rx_axis_tvalid, output, 1 bit: payload byte valid, single-cycle pulse per byte.
REQ-012 SHALL have port m_rx_axis_tlast, output, 1 bit: marks the final payload byte.
REQ-013 SHALL have port m_rx_axis_tuser, output, 1 bit: bad-frame flag; meaningful only when tlast=1.

Function
REQ-014 SHALL accept a byte only on cycles where rgmii_mac_rx_dv=1 and rgmii_mac_rx_rdy=1.
REQ-015 SHALL implement the states IDLE, PREAMBLE, PAYLOAD and DROP.
REQ-016 SHALL go from IDLE to PREAMBLE when it accepts a byte of 0x55.
REQ-017 SHALL, in PREAMBLE, count accepted 0x55 bytes and go to PAYLOAD when it accepts 0xD5 after 1 to 7 bytes of 0x55.
REQ-018 SHALL go from PREAMBLE to DROP on any other accepted byte, and on a 0xD5 accepted with no preceding 0x55.
REQ-019 SHALL return from PREAMBLE to IDLE when rgmii_mac_rx_dv falls, with no output.
REQ-020 SHALL, in PAYLOAD, shift each accepted byte into a 4-byte FCS delay line; the byte leaving the delay line becomes the held byte.
REQ-021 SHALL, when a new byte is accepted while a held byte exists, emit the held byte with tvalid=1 and tlast=0 on the following cycle.
REQ-022 SHALL, on the cycle after rgmii_mac_rx_dv falls in PAYLOAD, emit the held byte with tvalid=1, tlast=1 and tuser set to the frame status, then go to IDLE.
REQ-023 SHALL discard a frame that ends with fewer than 5 bytes after the SFD, with no output.
REQ-024 SHALL keep a byte counter of 11 bits that saturates at 2047.
REQ-025 SHALL set the frame status bit (tuser=1) if the count is below MIN_FRAME, the count exceeds MAX_FRAME, rgmii_mac_rx_er was seen, or the CRC check fails (REQ-031).
REQ-026 SHALL, on rgmii_mac_rx_er in PAYLOAD, set the error status and keep forwarding bytes until rgmii_mac_rx_dv falls.
REQ-027 SHALL, in DROP, ignore all input until rgmii_mac_rx_dv=0, then go to IDLE.
REQ-028 SHALL assert m_rx_axis_tvalid with fixed timing; it has no backpressure input and the downstream FIFO must always accept.
REQ-029 SHALL, when rgmii_mac_rx_dv falls and rises again on consecutive cycles, close the first frame as in REQ-022 before it accepts the second preamble.

Reset
REQ-030 SHALL, while reset_n=0 at any time, force the state to IDLE, clear the counter, the delay line, the held byte and the status, drive all outputs to 0, and leave any frame in progress with no tlast.

Configuration
REQ-031 SHALL, when RX_MAC_CRC_CHECK_EN is defined, compute a reflected CRC-32 (polynomial 0xEDB88320, initial value 0xFFFFFFFF) over every byte after the SFD, FCS included, and treat the CRC as failed when the final register value is not 0xDEBB20E3.
REQ-032 SHALL, when RX_MAC_CRC_CHECK_EN is undefined, contain no CRC logic; the FCS is still stripped and tuser reflects only length and rgmii_mac_rx_er.

Verification
REQ-033 SHALL cover a good frame: 7x0x55, 0xD5, 60 payload bytes, valid FCS, rdy=1 every cycle -> 60 tvalid pulses, tlast on byte 60, tuser=0.
REQ-034 SHALL cover a corrupted FCS: the same frame with the last FCS byte XOR 0x01 -> tuser=1 with the macro defined, tuser=0 with it undefined.
REQ-035 SHALL cover MII pacing: the same frame with rdy toggling each cycle -> identical byte sequence, tvalid spaced 2 cycles apart, tuser=0.
REQ-036 SHALL cover a runt: 20 bytes after the SFD -> 16 bytes out with tuser=1; 3 bytes after the SFD -> no output.
REQ-037 SHALL cover a bad preamble: 0x55, 0x55, 0x12, then data -> no output until dv=0; the next good frame is received normally.
REQ-038 SHALL cover reset mid-payload: reset_n=0 after byte 30 of the good frame -> outputs 0 within the reset; the next frame after release is received with tuser=0.

Source files
------------

// File: rtl/rx_mac.sv
`default_nettype none
// ============================================================================
// rx_mac : RGMII receive MAC -- preamble/SFD strip, FCS strip, AXI-Stream out.
// Optional CRC-32 check enabled by defining RX_MAC_CRC_CHECK_EN.
// Revision: 1.0
// ============================================================================
module rx_mac #(
    parameter int DATA_WIDTH = 8,
    parameter int MIN_FRAME  = 64,
    parameter int MAX_FRAME  = 1518
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] rgmii_mac_rx_data,
    input  logic                  rgmii_mac_rx_dv,
    input  logic                  rgmii_mac_rx_er,
    input  logic                  rgmii_mac_rx_rdy,
    output logic [DATA_WIDTH-1:0] m_rx_axis_tdata,
    output logic                  m_rx_axis_tvalid,
    output logic                  m_rx_axis_tlast,
    output logic                  m_rx_axis_tuser
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        PAYLOAD  = 2'd2,
        DROP     = 2'd3
    } state_e;

    localparam logic [DATA_WIDTH-1:0] PRE_BYTE = DATA_WIDTH'(8'h55);
    localparam logic [DATA_WIDTH-1:0] SFD_BYTE = DATA_WIDTH'(8'hD5);
    localparam logic [10:0]           MIN_LEN  = 11'(MIN_FRAME);
    localparam logic [10:0]           MAX_LEN  = 11'(MAX_FRAME);
    localparam logic [10:0]           CNT_SAT  = 11'h7FF;

    state_e                           state_q, state_d;
    logic [2:0]                       pre_cnt_q, pre_cnt_d;
    logic [3:0][DATA_WIDTH-1:0]       dl_q, dl_d;
    logic [2:0]                       fill_q, fill_d;
    logic [DATA_WIDTH-1:0]            held_q, held_d;
    logic                             held_vld_q, held_vld_d;
    logic [10:0]                      cnt_q, cnt_d;
    logic                             err_q, err_d;
    logic [DATA_WIDTH-1:0]            tdata_q, tdata_d;
    logic                             tvalid_q, tvalid_d;
    logic                             tlast_q, tlast_d;
    logic                             tuser_q, tuser_d;

    logic                             w_accept;
    logic                             w_sfd_hit;
    logic                             w_pay_byte;
    logic                             w_crc_bad;
    logic                             w_status;

    assign w_accept   = rgmii_mac_rx_dv & rgmii_mac_rx_rdy;
    assign w_sfd_hit  = (state_q == PREAMBLE) && w_accept &&
                        (rgmii_mac_rx_data == SFD_BYTE) && (pre_cnt_q != 3'd0);
    assign w_pay_byte = (state_q == PAYLOAD) && w_accept;

`ifdef RX_MAC_CRC_CHECK_EN
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

    logic [31:0] crc_q, crc_d;

    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    // Running over data plus FCS leaves the fixed residue on a good frame.
    always_comb begin
        crc_d = crc_q;
        if (w_sfd_hit) begin
            crc_d = CRC_INIT;
        end else if (w_pay_byte) begin
            crc_d = crc32_byte(crc_q, rgmii_mac_rx_data[7:0]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign w_crc_bad = (crc_q != CRC_RESIDUE);
`else
    assign w_crc_bad = 1'b0;
`endif

    assign w_status = (cnt_q < MIN_LEN) || (cnt_q > MAX_LEN) || err_q || w_crc_bad;

    always_comb begin
        state_d    = state_q;
        pre_cnt_d  = pre_cnt_q;
        dl_d       = dl_q;
        fill_d     = fill_q;
        held_d     = held_q;
        held_vld_d = held_vld_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        tdata_d    = '0;
        tvalid_d   = 1'b0;
        tlast_d    = 1'b0;
        tuser_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (w_accept) begin
                    if (rgmii_mac_rx_data == PRE_BYTE) begin
                        state_d   = PREAMBLE;
                        pre_cnt_d = 3'd1;
                    end else begin
                        // Joined mid-frame: wait for dv to drop.
                        state_d = DROP;
                    end
                end
            end

            PREAMBLE: begin
                if (!rgmii_mac_rx_dv) begin
                    state_d = IDLE;
                end else if (w_sfd_hit) begin
                    state_d    = PAYLOAD;
                    fill_d     = 3'd0;
                    held_vld_d = 1'b0;
                    cnt_d      = '0;
                    err_d      = 1'b0;
                end else if (w_accept) begin
                    if ((rgmii_mac_rx_data == PRE_BYTE) && (pre_cnt_q != 3'd7)) begin
                        pre_cnt_d = pre_cnt_q + 3'd1;
                    end else begin
                        state_d = DROP;
                    end
                end
            end

            PAYLOAD: begin
                if (!rgmii_mac_rx_dv) begin
                    if (held_vld_q) begin
                        tvalid_d = 1'b1;
                        tlast_d  = 1'b1;
                        tuser_d  = w_status;
                        tdata_d  = held_q;
                    end
                    state_d    = IDLE;
                    held_vld_d = 1'b0;
                    fill_d     = 3'd0;
                end else begin
                    if (rgmii_mac_rx_er) begin
                        err_d = 1'b1;
                    end
                    if (w_pay_byte) begin
                        cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 11'd1;
                        dl_d  = {dl_q[2:0], rgmii_mac_rx_data};
                        // The byte leaving the FCS window is only known not
                        // to be the last payload byte once another arrives.
                        if (fill_q == 3'd4) begin
                            held_d     = dl_q[3];
                            held_vld_d = 1'b1;
                            if (held_vld_q) begin
                                tvalid_d = 1'b1;
                                tdata_d  = held_q;
                            end
                        end else begin
                            fill_d = fill_q + 3'd1;
                        end
                    end
                end
            end

            DROP: begin
                if (!rgmii_mac_rx_dv) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            pre_cnt_q  <= '0;
            dl_q       <= '0;
            fill_q     <= '0;
            held_q     <= '0;
            held_vld_q <= 1'b0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            tuser_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_cnt_q  <= pre_cnt_d;
            dl_q       <= dl_d;
            fill_q     <= fill_d;
            held_q     <= held_d;
            held_vld_q <= held_vld_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            tuser_q    <= tuser_d;
        end
    end

    assign m_rx_axis_tdata  = tdata_q;
    assign m_rx_axis_tvalid = tvalid_q;
    assign m_rx_axis_tlast  = tlast_q;
    assign m_rx_axis_tuser  = tuser_q;

endmodule
`default_nettype wire
